prbs_gen_chk: RTL and testbench
===============================

# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker for the DSP datapath. The generator produces a Fibonacci LFSR sequence of configurable length and tap set, one bit per qualified step. The checker recovers alignment from a received bit stream, declares lock, and counts bit errors. It replaces the fixed 9-bit generator in BER and loopback test paths: the transmit side drives `bit_out` into the modulator, and the receive side feeds slicer decisions into `chk_in`.

## Interface
Parameters:
- `N`, 9: LFSR length in bits, legal range 3..32.
- `TAPS`, 9'h011: feedback mask, N bits wide. Feedback is the XOR of `state[i]` for every i where `TAPS[i]=1`. The default (bits 0 and 4) is PRBS9.
- `SEED`, 9'h1FF: generator reset state, N bits wide. A value of 0 is legal (see Operation).
- `LOCK_CNT`, 16: consecutive correct predictions required to declare lock, range 1..255.
- `LOSS_CNT`, 8: consecutive errors while locked that drop lock, range 1..255.
- `ERRW`, 16: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global enable; while low, generator and checker both hold.
- `valid`  in  1  generator step request.
- `bit_out`  out  1  generator output, equal to `gen_state[0]`.
- `chk_in`  in  1  received bit.
- `chk_valid`  in  1  qualifies `chk_in`.
- `clear_err`  in  1  synchronous clear of the error counter.
- `locked`  out  1  high while the checker FSM is in LOCKED.
- `err_pulse`  out  1  one-cycle flag for an error detected while locked.
- `err_count`  out  ERRW  saturating count of errors detected while locked.

## Operation
Generator:
- Steps when `enable & valid` is high: `gen_state <= {fb, gen_state[N-1:1]}`, where fb = ^(gen_state & TAPS).
- Lock-up escape: if `gen_state` is all-zero at a step, it loads all-ones instead.

Checker:
- Steps only when `enable & chk_valid` is high. No event occurs on any other cycle.
- Register `chk_reg` is N bits. Prediction `exp` = ^(chk_reg & TAPS).
- FSM states:
  - FILL: `chk_reg <= {chk_in, chk_reg[N-1:1]}`. After N steps, go to SYNC with the match counter at 0.
  - SYNC: `chk_reg` shifts in `chk_in`, not `exp`. On `chk_in==exp`, increment the match counter; on the step reaching LOCK_CNT, go to LOCKED. On a mismatch, reset the match counter to 0 and stay in SYNC.
  - LOCKED: `chk_reg <= {exp, chk_reg[N-1:1]}`. Using the prediction rather than `chk_in` means a single corrupted bit yields exactly one error.
    - On a mismatch: `err_pulse` goes high and `err_count` increments, saturating at 2^ERRW-1. The consecutive-error counter increments.
    - On a match: the consecutive-error counter clears.
    - On the step reaching LOSS_CNT consecutive errors: go to FILL (that error is still counted), and clear all FSM counters.
- `clear_err`: sets `err_count` to 0 on the next edge. It has priority over a simultaneous increment, so the result is 0. It does not affect FSM state.

## Timing
- Reset values:
  - `gen_state`=SEED, so `bit_out`=SEED[0].
  - `chk_reg`=0; FSM=FILL; all counters 0.
  - `locked`=0, `err_pulse`=0, `err_count`=0.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values. There is no partial state.
- `bit_out` is registered: new value one cycle after the qualifying edge. No combinational path from inputs to outputs.
- `locked` rises on the edge that consumes the LOCK_CNT-th consecutive match. It falls on the edge that consumes the LOSS_CNT-th consecutive error.
- `err_pulse` is high for exactly the cycle following the edge that consumed the mismatching bit; otherwise low. `err_count` updates on that same edge.
- Minimum acquisition from reset with a clean stream is N + LOCK_CNT qualified checker steps (25 with defaults). Gaps in `chk_valid` stretch this but do not break it.
- With `enable` low, inputs are ignored and all state holds, including a pending `clear_err`, which is dropped.

## Test plan
- Reset with defaults, `enable=valid=1` -> `bit_out` is 1 for the first 9 cycles, then 0,0; the period is 511 steps with 256 ones.
- Loopback `bit_out`->`chk_in`, `chk_valid=valid=1` -> `locked` rises after exactly 25 steps; `err_count` stays 0 over 2000 steps.
- Locked, invert one `chk_in` bit -> exactly one `err_pulse`, `err_count`=1, `locked` stays 1. Then assert `clear_err` in the same cycle as a second injected error -> `err_count`=0.
- Locked, invert 7 consecutive bits -> `err_count`=7, still locked. Invert 8 consecutive bits -> `locked` falls on the 8th; `err_count`=8 (or 15 cumulative); relock after 25 more clean steps.
- SEED=0 instance -> first step loads 9'h1FF, after which `bit_out` follows the sequence from the first test; `chk_valid` toggled randomly -> lock timing counts only qualified steps.
- `rst` pulsed low while locked with `err_count`=3 -> `locked`=0, `err_count`=0 and `bit_out`=SEED[0] asynchronously, before the next clock edge.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// Parametrised Fibonacci PRBS generator and self-synchronising checker.
// The checker fills, acquires sync, then free-runs on its own prediction.
module prbs_gen_chk #(
    parameter int             N        = 9,
    parameter logic [N-1:0]   TAPS     = 9'h011,
    parameter logic [N-1:0]   SEED     = 9'h1FF,
    parameter int             LOCK_CNT = 16,
    parameter int             LOSS_CNT = 8,
    parameter int             ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            valid,
    output logic            bit_out,
    input  logic            chk_in,
    input  logic            chk_valid,
    input  logic            clear_err,
    output logic            locked,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_count
);

    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {
        FILL,
        SYNC,
        LOCKED
    } state_t;

    state_t         state;
    logic [N-1:0]   gen_state;
    logic [N-1:0]   chk_reg;
    logic [FW-1:0]  fill_cnt;
    logic [7:0]     match_cnt;
    logic [7:0]     loss_cnt;
    logic           gen_step;
    logic           chk_step;
    logic           exp_bit;
    logic           miss;

    assign gen_step = enable & valid;
    assign chk_step = enable & chk_valid;
    assign exp_bit  = ^(chk_reg & TAPS);
    assign miss     = chk_in ^ exp_bit;
    assign bit_out  = gen_state[0];

    // An all-zero state would stick, so it is replaced by all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_state <= SEED;
        end else if (gen_step) begin
            if (gen_state == '0) begin
                gen_state <= '1;
            end else begin
                gen_state <= {^(gen_state & TAPS), gen_state[N-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            chk_reg   <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            loss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (chk_step) begin
                unique case (state)
                    FILL: begin
                        chk_reg <= {chk_in, chk_reg[N-1:1]};
                        if (fill_cnt == FW'(N - 1)) begin
                            state     <= SYNC;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    SYNC: begin
                        chk_reg <= {chk_in, chk_reg[N-1:1]};
                        if (miss) begin
                            match_cnt <= '0;
                        end else if (match_cnt == 8'(LOCK_CNT - 1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            loss_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + 8'd1;
                        end
                    end
                    LOCKED: begin
                        // Feeding back the prediction keeps one bad bit
                        // from poisoning later predictions.
                        chk_reg <= {exp_bit, chk_reg[N-1:1]};
                        if (miss) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (loss_cnt == 8'(LOSS_CNT - 1)) begin
                                state     <= FILL;
                                locked    <= 1'b0;
                                loss_cnt  <= '0;
                                match_cnt <= '0;
                                fill_cnt  <= '0;
                            end else begin
                                loss_cnt <= loss_cnt + 8'd1;
                            end
                        end else begin
                            loss_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= FILL;
                    end
                endcase
            end
            if (enable && clear_err) begin
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Randomised bench for prbs_gen_chk against a sequence-table and
// history-queue model; two instances (default and SEED=0, small counters).
module tb_prbs_gen_chk;

    localparam int PER    = 511;
    localparam int M_FILL = 0;
    localparam int M_SYNC = 1;
    localparam int M_LOCK = 2;
    localparam int LOCKC [2] = '{16, 4};
    localparam int LOSSC [2] = '{8, 3};
    localparam int EMAX  [2] = '{65535, 7};

    logic        clk = 1'b0;
    logic        rst, enable, valid, chk_valid, clear_err, inj;
    logic        valid0, inj0;
    logic        bit_out, locked, err_pulse, chk_in;
    logic [15:0] err_count;
    logic        bit_out0, locked0, err_pulse0, chk_in0;
    logic [2:0]  err_count0;

    int n_pass = 0;
    int n_tot  = 0;
    bit go0    = 1'b0;

    bit seq [PER];
    int pos [2];
    int fills [2];
    int runs [2];
    int misses [2];
    int errs [2];
    int mode [2];
    bit pulse [2];
    bit hist [2][$];

    assign chk_in  = bit_out ^ inj;
    assign chk_in0 = bit_out0 ^ inj0;

    prbs_gen_chk dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .valid     (valid),
        .bit_out   (bit_out),
        .chk_in    (chk_in),
        .chk_valid (chk_valid),
        .clear_err (clear_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs_gen_chk #(
        .SEED     (9'h000),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERRW     (3)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .valid     (valid0),
        .bit_out   (bit_out0),
        .chk_in    (chk_in0),
        .chk_valid (valid0),
        .clear_err (clear_err),
        .locked    (locked0),
        .err_pulse (err_pulse0),
        .err_count (err_count0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        n_tot++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic void mreset(int i);
        pos[i]    = 0;
        fills[i]  = 0;
        runs[i]   = 0;
        misses[i] = 0;
        errs[i]   = 0;
        mode[i]   = M_FILL;
        pulse[i]  = 1'b0;
        hist[i].delete();
        for (int k = 0; k < 9; k++) hist[i].push_back(1'b0);
    endfunction

    // hist holds the last nine accepted bits, oldest first.
    function automatic void mstep(int i, bit g, bit c, bit cin, bit clr);
        bit e;
        if (g) pos[i]++;
        pulse[i] = 1'b0;
        if (c) begin
            e = hist[i][0] ^ hist[i][4];
            void'(hist[i].pop_front());
            hist[i].push_back((mode[i] == M_LOCK) ? e : cin);
            if (mode[i] == M_FILL) begin
                fills[i]++;
                if (fills[i] == 9) begin
                    mode[i] = M_SYNC;
                    runs[i] = 0;
                end
            end else if (mode[i] == M_SYNC) begin
                if (cin == e) begin
                    runs[i]++;
                    if (runs[i] == LOCKC[i]) begin
                        mode[i]   = M_LOCK;
                        misses[i] = 0;
                    end
                end else begin
                    runs[i] = 0;
                end
            end else if (cin != e) begin
                pulse[i] = 1'b1;
                if (errs[i] < EMAX[i]) errs[i]++;
                misses[i]++;
                if (misses[i] == LOSSC[i]) begin
                    mode[i]   = M_FILL;
                    fills[i]  = 0;
                    misses[i] = 0;
                    runs[i]   = 0;
                end
            end else begin
                misses[i] = 0;
            end
        end
        if (clr) errs[i] = 0;
    endfunction

    function automatic bit mbit(int i);
        if (i == 1) return (pos[1] == 0) ? 1'b0 : seq[(pos[1] - 1) % PER];
        return seq[pos[0] % PER];
    endfunction

    always @(negedge rst) begin
        mreset(0);
        mreset(1);
    end

    always @(posedge clk) begin
        if (rst) begin
            mstep(0, enable & valid, enable & chk_valid, chk_in,
                  enable & clear_err);
            mstep(1, enable & valid0, enable & valid0, chk_in0,
                  enable & clear_err);
            #1;
            if (rst) begin
                chk("bit_out", bit_out, mbit(0));
                chk("locked", locked, mode[0] == M_LOCK);
                chk("err_pulse", err_pulse, pulse[0]);
                chk("err_count", err_count, errs[0]);
                chk("bit_out0", bit_out0, mbit(1));
                chk("locked0", locked0, mode[1] == M_LOCK);
                chk("err_pulse0", err_pulse0, pulse[1]);
                chk("err_count0", err_count0, errs[1]);
            end
        end
    end

    initial begin
        wait (go0);
        forever begin
            @(negedge clk);
            valid0 = 1'($urandom_range(0, 1));
            inj0   = ($urandom_range(0, 39) == 0);
        end
    end

    initial begin
        int lockat, ones, q;
        bit v;
        rst = 0; enable = 0; valid = 0; chk_valid = 0;
        clear_err = 0; inj = 0; valid0 = 0; inj0 = 0;
        mreset(0);
        mreset(1);
        for (int i = 0; i < 9; i++) seq[i] = 1'b1;
        for (int i = 9; i < PER; i++) seq[i] = seq[i-9] ^ seq[i-5];

        repeat (2) @(negedge clk);
        chk("rst_bit_out", bit_out, 1);
        chk("rst_locked", locked, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_bit_out0", bit_out0, 0);

        rst = 1; enable = 1; valid = 1; chk_valid = 1; valid0 = 1;
        lockat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 10) chk($sformatf("prbs9_bit%0d", k), bit_out, (k < 9) ? 1 : 0);
            if (k == 1) begin
                chk("seed0_first_step", bit_out0, 1);
                go0 = 1'b1;
            end
            if (locked && lockat == 0) lockat = k;
        end
        chk("lock_steps", lockat, 25);

        ones = 0;
        for (int k = 0; k < PER; k++) begin
            ones += int'(bit_out);
            @(negedge clk);
        end
        chk("period_ones", ones, 256);
        repeat (1489) @(negedge clk);
        chk("clean_err_count", err_count, 0);
        chk("clean_locked", locked, 1);

        inj = 1;
        @(negedge clk);
        inj = 0;
        chk("single_pulse", err_pulse, 1);
        @(negedge clk);
        chk("single_pulse_low", err_pulse, 0);
        repeat (5) @(negedge clk);
        chk("single_count", err_count, 1);
        chk("single_locked", locked, 1);
        clear_err = 1; inj = 1;
        @(negedge clk);
        clear_err = 0; inj = 0;
        chk("clear_priority", err_count, 0);
        repeat (5) @(negedge clk);

        inj = 1;
        repeat (7) @(negedge clk);
        inj = 0;
        repeat (3) @(negedge clk);
        chk("burst7_count", err_count, 7);
        chk("burst7_locked", locked, 1);

        inj = 1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 7) chk("burst8_locked_at7", locked, 1);
            if (j == 8) chk("burst8_loss_at8", locked, 0);
        end
        inj = 0;
        chk("burst8_count", err_count, 15);
        lockat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (locked && lockat == 0) lockat = k;
        end
        chk("relock_steps", lockat, 25);

        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            valid     = 1'($urandom_range(0, 1));
            chk_valid = (i < 1500) ? valid : 1'($urandom_range(0, 1));
            inj       = ($urandom_range(0, 39) == 0);
            clear_err = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end

        enable = 1; valid = 1; chk_valid = 1; inj = 0; clear_err = 0;
        rst = 0;
        @(negedge clk);
        rst = 1;
        q = 0;
        lockat = 0;
        for (int k = 0; k < 200; k++) begin
            v = 1'($urandom_range(0, 1));
            valid = v;
            chk_valid = v;
            @(negedge clk);
            if (v) q++;
            if (locked && lockat == 0) lockat = q;
        end
        chk("gap_lock_steps", lockat, 25);

        valid = 1; chk_valid = 1;
        repeat (10) @(negedge clk);
        for (int e = 0; e < 3; e++) begin
            inj = 1;
            @(negedge clk);
            inj = 0;
            repeat (4) @(negedge clk);
        end
        chk("pre_rst_count", err_count, 3);
        chk("pre_rst_locked", locked, 1);
        #2 rst = 0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_err_count", err_count, 0);
        chk("async_bit_out", bit_out, 1);
        chk("async_err_pulse", err_pulse, 0);
        chk("async_locked0", locked0, 0);
        chk("async_bit_out0", bit_out0, 0);
        @(negedge clk);
        rst = 1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
